div_sched: RTL and testbench

- Sequencer and two-requester round-robin arbiter for the shared 24-bit iterative divider.
- Accepts divide requests from two clients and drives the divider's clock-enable, local reset and operand inputs.
- Counts the divider's fixed iteration latency, captures the quotient and returns it on a shared result port with a valid/ack handshake.
- Short-circuits divide-by-zero without starting the divider.

---
 rtl/div_sched_if.sv | 35 +++
 rtl/div_sched.sv | 142 ++++++++++++++
 tb/tb_div_sched.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/div_sched_if.sv
// Client, divider and result signals of the divider scheduler, grouped into one bundle.
// The scheduler uses the slave modport; clients and divider sit on the master side.
interface div_sched_if #(
  parameter int C_NUM_BITS = 24
);
  logic                  REQ0;
  logic                  REQ1;
  logic [C_NUM_BITS-1:0] A0;
  logic [C_NUM_BITS-1:0] B0;
  logic [C_NUM_BITS-1:0] A1;
  logic [C_NUM_BITS-1:0] B1;
  logic                  GNT0;
  logic                  GNT1;
  logic                  DIV_E;
  logic                  DIV_RN;
  logic [C_NUM_BITS-1:0] DIV_A;
  logic [C_NUM_BITS-1:0] DIV_B;
  logic [C_NUM_BITS-1:0] DIV_Q;
  logic [C_NUM_BITS-1:0] RES;
  logic                  RES_ID;
  logic                  RES_DZ;
  logic                  RES_VLD;
  logic                  RES_ACK;
  logic                  BUSY;

  modport master (
    output REQ0, REQ1, A0, B0, A1, B1, DIV_Q, RES_ACK,
    input  GNT0, GNT1, DIV_E, DIV_RN, DIV_A, DIV_B, RES, RES_ID, RES_DZ, RES_VLD, BUSY
  );

  modport slave (
    input  REQ0, REQ1, A0, B0, A1, B1, DIV_Q, RES_ACK,
    output GNT0, GNT1, DIV_E, DIV_RN, DIV_A, DIV_B, RES, RES_ID, RES_DZ, RES_VLD, BUSY
  );
endinterface

// File: rtl/div_sched.sv
// Two-client round-robin scheduler for a shared iterative divider: grants, sequences
// the divider's local reset/clock-enable for a fixed latency and returns the quotient.
module div_sched #(
  parameter int C_NUM_BITS   = 24,
  parameter int C_DIV_CYCLES = 50,
  parameter int C_CNT_BITS   = 8
) (
  input  logic      CK,
  input  logic      RN,
  div_sched_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [C_CNT_BITS-1:0] C_LAST = C_CNT_BITS'(C_DIV_CYCLES - 1);

  logic [2:0]            r_state;
  logic [C_CNT_BITS-1:0] r_cnt;
  logic                  r_ptr;
  logic                  r_id;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  r_div_e;
  logic                  r_div_rn;
  logic [C_NUM_BITS-1:0] r_div_a;
  logic [C_NUM_BITS-1:0] r_div_b;
  logic [C_NUM_BITS-1:0] r_res;
  logic                  r_res_id;
  logic                  r_res_dz;
  logic                  r_res_vld;
  logic                  r_busy;

  logic                  w_any_req;
  logic                  w_pick;
  logic [C_NUM_BITS-1:0] w_a;
  logic [C_NUM_BITS-1:0] w_b;

  // On contention the client that was not granted last wins; a lone requester always wins.
  assign w_any_req = bus.REQ0 | bus.REQ1;
  assign w_pick    = (bus.REQ0 & bus.REQ1) ? ~r_ptr : bus.REQ1;
  assign w_a       = w_pick ? bus.A1 : bus.A0;
  assign w_b       = w_pick ? bus.B1 : bus.B0;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ptr     <= 1'b1;
      r_id      <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_div_e   <= 1'b0;
      r_div_rn  <= 1'b0;
      r_div_a   <= '0;
      r_div_b   <= '0;
      r_res     <= '0;
      r_res_id  <= 1'b0;
      r_res_dz  <= 1'b0;
      r_res_vld <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_ptr   <= w_pick;
            r_id    <= w_pick;
            r_div_a <= w_a;
            r_div_b <= w_b;
            r_busy  <= 1'b1;
            if (w_b == '0) begin
              // Divide-by-zero never touches the divider; the result is ready at once.
              r_res     <= '1;
              r_res_dz  <= 1'b1;
              r_res_id  <= w_pick;
              r_res_vld <= 1'b1;
              r_state   <= S_RESP;
            end else begin
              r_state <= S_CLR;
            end
          end
        end
        S_CLR: begin
          r_div_rn <= 1'b1;
          r_div_e  <= 1'b1;
          r_cnt    <= '0;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_div_e <= 1'b0;
            r_state <= S_CAPT;
          end
        end
        S_CAPT: begin
          r_res     <= bus.DIV_Q;
          r_res_dz  <= 1'b0;
          r_res_id  <= r_id;
          r_res_vld <= 1'b1;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (bus.RES_ACK) begin
            r_res_vld <= 1'b0;
            r_div_rn  <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_div_e   <= 1'b0;
          r_div_rn  <= 1'b0;
          r_res_vld <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.GNT0    = r_gnt0;
  assign bus.GNT1    = r_gnt1;
  assign bus.DIV_E   = r_div_e;
  assign bus.DIV_RN  = r_div_rn;
  assign bus.DIV_A   = r_div_a;
  assign bus.DIV_B   = r_div_b;
  assign bus.RES     = r_res;
  assign bus.RES_ID  = r_res_id;
  assign bus.RES_DZ  = r_res_dz;
  assign bus.RES_VLD = r_res_vld;
  assign bus.BUSY    = r_busy;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a latency-accurate divider model: the quotient is
// only valid after 50 enabled cycles following the divider's local reset release.
module tb_div_sched;

  logic CK = 1'b0;
  logic RN;
  int   n_checks = 0;
  int   n_errors = 0;

  div_sched_if #(.C_NUM_BITS(24)) bus ();

  div_sched #(.C_NUM_BITS(24), .C_DIV_CYCLES(50), .C_CNT_BITS(8)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  always #5 CK = ~CK;

  // Divider model: counts gated cycles since local reset; garbage until the latency is met.
  logic [7:0] m_cnt;
  always @(posedge CK or negedge bus.DIV_RN) begin
    if (!bus.DIV_RN)                            m_cnt <= 8'd0;
    else if (bus.DIV_E === 1'b1 && m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
  end
  assign bus.DIV_Q = (m_cnt >= 8'd50 && bus.DIV_B != 24'd0) ? bus.DIV_A / bus.DIV_B : 24'h5A5A5A;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Called right after the grant edge; waits for RES_VLD and checks latency, enable width and result.
  task automatic serve(input string tag, input logic [23:0] exp_res, input logic exp_id,
                       input logic exp_dz, input int exp_lat);
    int          n = 0;
    int          e = 0;
    int          unstable = 0;
    logic [23:0] a0 = bus.DIV_A;
    logic [23:0] b0 = bus.DIV_B;
    while (bus.RES_VLD !== 1'b1 && n < 200) begin
      if (bus.DIV_E === 1'b1) e++;
      if (bus.DIV_A !== a0 || bus.DIV_B !== b0) unstable++;
      tick();
      n++;
      if (n == 1) check({tag, "_gnt_pulse"}, {30'd0, bus.GNT0, bus.GNT1}, 32'd0);
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_div_e_cycles"}, e, exp_dz ? 0 : 50);
    check({tag, "_operands_held"}, unstable, 0);
    check({tag, "_res"}, {8'd0, bus.RES}, {8'd0, exp_res});
    check({tag, "_res_id"}, {31'd0, bus.RES_ID}, {31'd0, exp_id});
    check({tag, "_res_dz"}, {31'd0, bus.RES_DZ}, {31'd0, exp_dz});
  endtask

  initial begin
    int bad;
    RN = 1'b0;
    bus.REQ0 = 1'b0; bus.A0 = '0; bus.B0 = '0;
    bus.REQ1 = 1'b0; bus.A1 = '0; bus.B1 = '0;
    bus.RES_ACK = 1'b0;
    repeat (3) @(posedge CK);
    #1;

    check("rst_gnt", {30'd0, bus.GNT0, bus.GNT1}, 32'd0);
    check("rst_div_ctl", {30'd0, bus.DIV_E, bus.DIV_RN}, 32'd0);
    check("rst_div_ops", {bus.DIV_A[15:0], bus.DIV_B[15:0]}, 32'd0);
    check("rst_res", {8'd0, bus.RES}, 32'd0);
    check("rst_res_flags", {28'd0, bus.RES_ID, bus.RES_DZ, bus.RES_VLD, bus.BUSY}, 32'd0);

    RN = 1'b1;
    bus.RES_ACK = 1'b1;
    tick();
    check("idle_busy", {31'd0, bus.BUSY}, 32'd0);

    // Contention straight after reset: client 0 first, then client 1.
    bus.REQ0 = 1'b1; bus.A0 = 24'd1000; bus.B0 = 24'd10;
    bus.REQ1 = 1'b1; bus.A1 = 24'd81;   bus.B1 = 24'd9;
    tick();
    check("c1_gnt", {30'd0, bus.GNT0, bus.GNT1}, 32'd2);
    check("c1_ops", {8'd0, bus.DIV_A}, 32'd1000);
    check("c1_busy", {31'd0, bus.BUSY}, 32'd1);
    bus.REQ0 = 1'b0;
    serve("c1", 24'd100, 1'b0, 1'b0, 52);
    tick();
    check("c1_vld_fall", {30'd0, bus.RES_VLD, bus.BUSY}, 32'd0);
    tick();
    check("c2_gnt", {30'd0, bus.GNT0, bus.GNT1}, 32'd1);
    bus.REQ1 = 1'b0;
    serve("c2", 24'd9, 1'b1, 1'b0, 52);
    tick();

    // Single request from client 0.
    bus.REQ0 = 1'b1; bus.A0 = 24'd100; bus.B0 = 24'd7;
    tick();
    check("s_gnt", {30'd0, bus.GNT0, bus.GNT1}, 32'd2);
    bus.REQ0 = 1'b0;
    serve("s", 24'd14, 1'b0, 1'b0, 52);
    tick();
    check("s_vld_one_cycle", {31'd0, bus.RES_VLD}, 32'd0);

    // Second simultaneous pair after a client-0 grant: client 1 first, then client 0.
    bus.REQ0 = 1'b1; bus.A0 = 24'd20; bus.B0 = 24'd4;
    bus.REQ1 = 1'b1; bus.A1 = 24'd77; bus.B1 = 24'd11;
    tick();
    check("p1_gnt", {30'd0, bus.GNT0, bus.GNT1}, 32'd1);
    bus.REQ1 = 1'b0;
    serve("p1", 24'd7, 1'b1, 1'b0, 52);
    tick();
    tick();
    check("p2_gnt", {30'd0, bus.GNT0, bus.GNT1}, 32'd2);
    bus.REQ0 = 1'b0;
    serve("p2", 24'd5, 1'b0, 1'b0, 52);
    tick();

    // Divide-by-zero: result on the grant edge, divider untouched.
    bus.REQ1 = 1'b1; bus.A1 = 24'd5; bus.B1 = 24'd0;
    tick();
    check("dz_gnt", {30'd0, bus.GNT0, bus.GNT1}, 32'd1);
    check("dz_vld", {31'd0, bus.RES_VLD}, 32'd1);
    check("dz_div_ctl", {30'd0, bus.DIV_E, bus.DIV_RN}, 32'd0);
    bus.REQ1 = 1'b0;
    serve("dz", 24'hFFFFFF, 1'b1, 1'b1, 0);
    tick();
    check("dz_after_ack", {29'd0, bus.RES_VLD, bus.DIV_E, bus.DIV_RN}, 32'd0);

    // Ack stall with a pending request.
    bus.RES_ACK = 1'b0;
    bus.REQ0 = 1'b1; bus.A0 = 24'd50; bus.B0 = 24'd5;
    tick();
    bus.REQ0 = 1'b0;
    serve("st", 24'd10, 1'b0, 1'b0, 52);
    bus.REQ0 = 1'b1; bus.A0 = 24'd60; bus.B0 = 24'd6;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.RES_VLD !== 1'b1 || bus.RES !== 24'd10 || bus.RES_ID !== 1'b0 ||
          bus.GNT0 !== 1'b0 || bus.GNT1 !== 1'b0) bad++;
    end
    check("st_hold_stable", bad, 0);
    bus.RES_ACK = 1'b1;
    tick();
    check("st_release", {29'd0, bus.RES_VLD, bus.BUSY, bus.GNT0}, 32'd0);
    tick();
    check("st_next_gnt", {30'd0, bus.GNT0, bus.GNT1}, 32'd2);
    check("st_next_ops", {8'd0, bus.DIV_A}, 32'd60);
    bus.REQ0 = 1'b0;
    serve("st2", 24'd10, 1'b0, 1'b0, 52);
    tick();

    // Reset in the middle of RUN, at counter = 20.
    bus.REQ0 = 1'b1; bus.A0 = 24'd500; bus.B0 = 24'd5;
    tick();
    bus.REQ0 = 1'b0;
    repeat (21) tick();
    check("mr_running", {30'd0, bus.DIV_E, bus.DIV_RN}, 32'd3);
    RN = 1'b0;
    #1;
    check("mr_ctl_zero", {27'd0, bus.DIV_E, bus.DIV_RN, bus.BUSY, bus.RES_VLD, bus.GNT0}, 32'd0);
    check("mr_ops_zero", {8'd0, bus.DIV_A}, 32'd0);
    tick();
    tick();
    RN = 1'b1;
    tick();
    check("mr_idle", {30'd0, bus.BUSY, bus.RES_VLD}, 32'd0);
    bus.REQ0 = 1'b1; bus.A0 = 24'd9; bus.B0 = 24'd3;
    tick();
    check("mr_gnt", {30'd0, bus.GNT0, bus.GNT1}, 32'd2);
    bus.REQ0 = 1'b0;
    serve("mr", 24'd3, 1'b0, 1'b0, 52);
    tick();

    // Boundary operands.
    bus.REQ0 = 1'b1; bus.A0 = 24'hFFFFFF; bus.B0 = 24'd1;
    tick();
    bus.REQ0 = 1'b0;
    serve("bmax", 24'hFFFFFF, 1'b0, 1'b0, 52);
    tick();
    bus.REQ1 = 1'b1; bus.A1 = 24'd3; bus.B1 = 24'd7;
    tick();
    check("bsmall_gnt", {30'd0, bus.GNT0, bus.GNT1}, 32'd1);
    bus.REQ1 = 1'b0;
    serve("bsmall", 24'd0, 1'b1, 1'b0, 52);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
